// File: rtl/temporizador_regressivo_if.sv
// Control/status bundle of the countdown timer: load/clear/enable in, count and flags out.
// Clock and asynchronous reset stay as plain ports on the timer itself.
interface temporizador_regressivo_if #(
    parameter int N = 7
);
    logic         zera_s;
    logic         carrega;
    logic [N-1:0] valor;
    logic         conta;
    logic [N-1:0] Q;
    logic         ativo;
    logic         fim;
    logic         meio;
    logic         quarto;

    modport master (
        output zera_s, carrega, valor, conta,
        input  Q, ativo, fim, meio, quarto
    );

    modport slave (
        input  zera_s, carrega, valor, conta,
        output Q, ativo, fim, meio, quarto
    );
endinterface

// File: rtl/temporizador_regressivo.sv
// Countdown timer: one-shot (AUTO=0) or auto-reload (AUTO=1), registered fim pulse on
// terminal count, combinational half/quarter flags relative to the last loaded value.
module temporizador_regressivo #(
    parameter int N    = 7,
    parameter bit AUTO = 1'b0
) (
    input  logic                      clock,
    input  logic                      zera_as_n,
    temporizador_regressivo_if.slave  bus
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CONTANDO  = 2'd1,
        TERMINADO = 2'd2
    } estado_t;

    estado_t      estado_q, estado_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] v_q, v_d;
    logic         fim_q, fim_d;

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado_q <= OCIOSO;
            q_q      <= '0;
            v_q      <= '0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            q_q      <= q_d;
            v_q      <= v_d;
            fim_q    <= fim_d;
        end
    end

    // Priority per edge: synchronous clear, then load, then decrement.
    always_comb begin
        estado_d = estado_q;
        q_d      = q_q;
        v_d      = v_q;
        fim_d    = 1'b0;

        if (bus.zera_s) begin
            estado_d = OCIOSO;
            q_d      = '0;
            v_d      = '0;
        end else if (bus.carrega) begin
            q_d = bus.valor;
            v_d = bus.valor;
            if (bus.valor == '0) begin
                estado_d = TERMINADO;
                fim_d    = 1'b1;
            end else begin
                estado_d = CONTANDO;
            end
        end else if (estado_q == CONTANDO && bus.conta) begin
            if (q_q > N'(1)) begin
                q_d = q_q - N'(1);
            end else if (q_q == N'(1)) begin
                fim_d = 1'b1;
                if (AUTO) begin
                    q_d = v_q;
                end else begin
                    q_d      = '0;
                    estado_d = TERMINADO;
                end
            end
        end
    end

    // Flags compare against the loaded value, so they track reloads automatically.
    assign bus.Q      = q_q;
    assign bus.fim    = fim_q;
    assign bus.ativo  = (estado_q == CONTANDO);
    assign bus.meio   = (estado_q == CONTANDO) && (v_q >= N'(2)) && (q_q == (v_q >> 1));
    assign bus.quarto = (estado_q == CONTANDO) && (v_q >= N'(4)) && (q_q == (v_q >> 2));

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Bench for the countdown timer: one-shot and auto-reload instances driven in lockstep,
// table vectors, directed corner sequences and random traffic against a reference model.
module tb_temporizador_regressivo;

    localparam int N = 7;

    logic clock;
    logic zera_as_n;

    temporizador_regressivo_if #(.N(N)) b0 ();
    temporizador_regressivo_if #(.N(N)) b1 ();

    temporizador_regressivo #(.N(N), .AUTO(1'b0)) u_one (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .bus       (b0)
    );

    temporizador_regressivo #(.N(N), .AUTO(1'b1)) u_auto (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .bus       (b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: k=0 one-shot, k=1 auto-reload. mode 0 idle, 1 counting, 2 finished.
    int m_mode [2];
    int m_q    [2];
    int m_v    [2];
    int m_fim  [2];

    typedef struct {
        bit zs;
        bit ld;
        int val;
        bit en;
        int q0;
        int fim0;
        int at0;
        int meio0;
        int quar0;
        int q1;
        int fim1;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_q[k]    = 0;
            m_v[k]    = 0;
            m_fim[k]  = 0;
        end
    endtask

    task automatic model_step(input int k, input bit zs, input bit ld, input int val, input bit en);
        m_fim[k] = 0;
        if (zs) begin
            m_mode[k] = 0;
            m_q[k]    = 0;
            m_v[k]    = 0;
        end else if (ld) begin
            m_q[k]    = val;
            m_v[k]    = val;
            m_mode[k] = (val == 0) ? 2 : 1;
            m_fim[k]  = (val == 0) ? 1 : 0;
        end else if (m_mode[k] == 1 && en) begin
            if (m_q[k] > 1) begin
                m_q[k] = m_q[k] - 1;
            end else begin
                m_fim[k] = 1;
                if (k == 1) begin
                    m_q[k] = m_v[k];
                end else begin
                    m_q[k]    = 0;
                    m_mode[k] = 2;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int q, f, a, me, qu;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                q = int'(b0.Q); f = int'(b0.fim); a = int'(b0.ativo);
                me = int'(b0.meio); qu = int'(b0.quarto);
            end else begin
                q = int'(b1.Q); f = int'(b1.fim); a = int'(b1.ativo);
                me = int'(b1.meio); qu = int'(b1.quarto);
            end
            chk($sformatf("%s[%0d].Q", tag, k), q, m_q[k]);
            chk($sformatf("%s[%0d].fim", tag, k), f, m_fim[k]);
            chk($sformatf("%s[%0d].ativo", tag, k), a, (m_mode[k] == 1) ? 1 : 0);
            chk($sformatf("%s[%0d].meio", tag, k), me,
                (m_mode[k] == 1 && m_v[k] >= 2 && m_q[k] == m_v[k] / 2) ? 1 : 0);
            chk($sformatf("%s[%0d].quarto", tag, k), qu,
                (m_mode[k] == 1 && m_v[k] >= 4 && m_q[k] == m_v[k] / 4) ? 1 : 0);
        end
    endtask

    // Inputs are applied just after a falling edge; outputs are checked at the next falling edge.
    task automatic cycle(input string tag, input bit zs, input bit ld, input int val, input bit en);
        b0.zera_s = zs; b0.carrega = ld; b0.valor = N'(val); b0.conta = en;
        b1.zera_s = zs; b1.carrega = ld; b1.valor = N'(val); b1.conta = en;
        @(posedge clock);
        model_step(0, zs, ld, val, en);
        model_step(1, zs, ld, val, en);
        @(negedge clock);
        compare_model(tag);
    endtask

    function automatic vec_t mk(bit zs, bit ld, int val, bit en, int q0, int fim0, int at0,
                                int meio0, int quar0, int q1, int fim1);
        vec_t v;
        v.zs = zs; v.ld = ld; v.val = val; v.en = en;
        v.q0 = q0; v.fim0 = fim0; v.at0 = at0; v.meio0 = meio0; v.quar0 = quar0;
        v.q1 = q1; v.fim1 = fim1;
        return v;
    endfunction

    initial begin
        int aq [6];
        int af [6];

        // One-shot count from 8, with auto-reload alongside.
        tbl.push_back(mk(0, 1, 8, 0, 8, 0, 1, 0, 0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 0, 1, 0, 0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 0, 1, 0, 0, 6, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 0, 1, 0, 0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 0, 1, 1, 0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0, 1, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 8, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 6, 0));
        // Zero load goes straight to finished with one fim pulse.
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // Load 10, count to 6, then clear wins over a simultaneous load.
        tbl.push_back(mk(0, 1, 10, 0, 10, 0, 1, 0, 0, 10, 0));
        tbl.push_back(mk(0, 0, 0, 1, 9, 0, 1, 0, 0, 9, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8, 0, 1, 0, 0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 0, 1, 0, 0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 0, 1, 0, 0, 6, 0));
        tbl.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        model_reset();
        zera_as_n = 1'b0;
        b0.zera_s = 0; b0.carrega = 0; b0.valor = '0; b0.conta = 0;
        b1.zera_s = 0; b1.carrega = 0; b1.valor = '0; b1.conta = 0;
        repeat (2) @(negedge clock);
        compare_model("reset");
        zera_as_n = 1'b1;

        cycle("idle_conta", 0, 0, 0, 1);
        cycle("idle_conta2", 0, 0, 0, 1);

        foreach (tbl[i]) begin
            cycle($sformatf("tbl%0d", i), tbl[i].zs, tbl[i].ld, tbl[i].val, tbl[i].en);
            chk($sformatf("tbl%0d.Q0", i), int'(b0.Q), tbl[i].q0);
            chk($sformatf("tbl%0d.fim0", i), int'(b0.fim), tbl[i].fim0);
            chk($sformatf("tbl%0d.ativo0", i), int'(b0.ativo), tbl[i].at0);
            chk($sformatf("tbl%0d.meio0", i), int'(b0.meio), tbl[i].meio0);
            chk($sformatf("tbl%0d.quarto0", i), int'(b0.quarto), tbl[i].quar0);
            chk($sformatf("tbl%0d.Q1", i), int'(b1.Q), tbl[i].q1);
            chk($sformatf("tbl%0d.fim1", i), int'(b1.fim), tbl[i].fim1);
        end

        // Auto-reload with 3: 3,2,1,3,2,1,3 and fim coincident with each reload.
        aq = '{2, 1, 3, 2, 1, 3};
        af = '{0, 0, 1, 0, 0, 1};
        cycle("ar_load", 0, 1, 3, 1);
        chk("ar_load.Q1", int'(b1.Q), 3);
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("ar%0d", i), 0, 0, 0, 1);
            chk($sformatf("ar%0d.Q1", i), int'(b1.Q), aq[i]);
            chk($sformatf("ar%0d.fim1", i), int'(b1.fim), af[i]);
        end

        // Pause and reload: 10 -> 7, hold through the pause, then reload 5.
        cycle("pz_load", 0, 1, 10, 0);
        for (int i = 0; i < 3; i++) cycle($sformatf("pz_run%0d", i), 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("pz_hold%0d", i), 0, 0, 0, 0);
            chk($sformatf("pz_hold%0d.Q0", i), int'(b0.Q), 7);
            chk($sformatf("pz_hold%0d.fim0", i), int'(b0.fim), 0);
        end
        cycle("pz_reload", 0, 1, 5, 0);
        chk("pz_reload.Q0", int'(b0.Q), 5);
        chk("pz_reload.fim0", int'(b0.fim), 0);

        // Asynchronous reset between edges while Q=4.
        cycle("rm_load", 0, 1, 6, 0);
        cycle("rm_run0", 0, 0, 0, 1);
        cycle("rm_run1", 0, 0, 0, 1);
        chk("rm_pre.Q0", int'(b0.Q), 4);
        #2 zera_as_n = 1'b0;
        #1;
        model_reset();
        compare_model("rm_async");
        chk("rm_async.Q0", int'(b0.Q), 0);
        #1 zera_as_n = 1'b1;
        @(negedge clock);
        compare_model("rm_after");
        cycle("rm_ld2", 0, 1, 2, 1);
        cycle("rm_c1", 0, 0, 0, 1);
        chk("rm_c1.Q0", int'(b0.Q), 1);
        cycle("rm_c0", 0, 0, 0, 1);
        chk("rm_c0.Q0", int'(b0.Q), 0);
        chk("rm_c0.fim0", int'(b0.fim), 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit zs, ld, en;
            int val;
            zs  = ($urandom_range(0, 31) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 3) != 0);
            val = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6))
                                              : int'($urandom_range(0, 127));
            cycle($sformatf("rnd%0d", i), zs, ld, val, en);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/temporizador_regressivo.md
TEMPORIZADOR_REGRESSIVO -- requirements
Module: temporizador_regressivo

Interface
REQ-001 Parameter N, default 7: width of the count and load value.
REQ-002 Parameter AUTO, default 0: 0 selects one-shot mode; 1 selects auto-reload mode.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port zera_as_n, input, 1: asynchronous, active-low reset.
REQ-005 Port zera_s, input, 1: synchronous clear to the idle state.
REQ-006 Port carrega, input, 1: load valor and start counting.
REQ-007 Port valor, input, N: initial count value, sampled when carrega is high.
REQ-008 Port conta, input, 1: decrement enable while counting.
REQ-009 Port Q, output, N: current count, registered.
REQ-010 Port ativo, output, 1: high while in state CONTANDO.
REQ-011 Port fim, output, 1: registered one-cycle pulse on terminal count.
REQ-012 Port meio, output, 1: combinational half-count flag.
REQ-013 Port quarto, output, 1: combinational quarter-count flag.

Function
REQ-014 The block SHALL implement an FSM with states OCIOSO, CONTANDO and TERMINADO, plus an internal N-bit register V holding the last loaded value.
REQ-015 Per-edge priority SHALL be: zera_s, then carrega, then conta.
REQ-016 When zera_s=1 in any state, the block SHALL go to OCIOSO with Q=0, V=0 and fim=0 on the next edge.
REQ-017 When carrega=1 (zera_s=0) in any state, the block SHALL set Q<=valor and V<=valor, and SHALL go to CONTANDO with fim=0; a reload during CONTANDO restarts the count.
REQ-018 When carrega=1 with valor=0, the block SHALL go directly to TERMINADO with Q=0, V=0 and fim=1 for one cycle.
REQ-019 In CONTANDO with conta=1, carrega=0 and Q>1, the block SHALL set Q<=Q-1.
REQ-020 In CONTANDO with conta=1, carrega=0, Q==1 and AUTO=0, the block SHALL set Q<=0, go to TERMINADO, and set fim=1 on that same edge.
REQ-021 In CONTANDO with conta=1, carrega=0, Q==1 and AUTO=1, the block SHALL set Q<=V, stay in CONTANDO, and set fim=1 on that same edge.
REQ-022 In CONTANDO with conta=0, the block SHALL hold Q; this is the pause behaviour.
REQ-023 In TERMINADO, the block SHALL hold Q=0 and ignore conta; it leaves only on carrega or zera_s.
REQ-024 In OCIOSO, the block SHALL hold Q=0 and ignore conta.
REQ-025 fim SHALL be high for exactly one cycle per terminal-count event and SHALL be 0 on every other edge.
REQ-026 meio SHALL be 1 iff state is CONTANDO and V>=2 and Q==V/2 (integer division, truncating).
REQ-027 quarto SHALL be 1 iff state is CONTANDO and V>=4 and Q==V/4 (integer division, truncating).
REQ-028 ativo SHALL equal (state==CONTANDO).
REQ-029 Q SHALL never underflow: no decrement occurs from 0, and Q never exceeds 2^N-1.

Reset
REQ-030 While zera_as_n=0, the block SHALL immediately force state=OCIOSO, Q=0, V=0 and fim=0, independent of clock.
REQ-031 Outputs under reset SHALL be ativo=0, meio=0 and quarto=0.
REQ-032 On deassertion of zera_as_n, operation SHALL resume at the next rising clock edge with no spurious fim pulse.
REQ-033 Reset asserted mid-count SHALL abort the count, with no fim pulse either during or after reset.

Verification
REQ-034 Scenario, one-shot (AUTO=0): carrega with valor=8, then conta held high. Required: Q goes 8,7,...,1,0; meio=1 at Q=4; quarto=1 at Q=2; fim=1 only on the edge where Q becomes 0; ativo drops at the same edge; Q stays 0 afterwards.
REQ-035 Scenario, auto-reload (AUTO=1): valor=3, conta held high for 7 cycles. Required: Q goes 3,2,1,3,2,1,3; fim pulses twice, each time coincident with the reload to 3.
REQ-036 Scenario, pause and reload: valor=10, conta=1 for 3 cycles (Q=7), conta=0 for 5 cycles, then carrega with valor=5. Required: Q holds 7 during the pause, then becomes 5; no fim pulse.
REQ-037 Scenario, priority: assert zera_s and carrega in the same cycle during CONTANDO at Q=6. Required: next state OCIOSO, Q=0, ativo=0.
REQ-038 Scenario, zero load: carrega with valor=0. Required: next state TERMINADO, Q=0, fim=1 for one cycle, meio=0, quarto=0.
REQ-039 Scenario, reset mid-count: pulse zera_as_n low between clock edges while Q=4. Required: Q=0 and ativo=0 immediately; fim stays 0 throughout; a later carrega with valor=2 counts normally.
